// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch queue.
//   NOP_INSTR     : instruction presented to ID when nothing is valid
//   FETCH_XLEN    : width of the pc field stored in each buffer entry (keep >= XLEN)
//   fetch_entry_t : one prefetch-buffer slot {pc, instr, filled[, misalign]}
//   ptr_width()   : index width for a DEPTH-entry circular buffer
// Optional feature macro: IF_MISALIGN_TRAP_EN adds the per-entry misalign flag.
package if_pkg;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
   localparam int          FETCH_XLEN = 32;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [31:0]           instr;
      logic                  filled;
`ifdef IF_MISALIGN_TRAP_EN
      logic                  misalign;
`endif
   } fetch_entry_t;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// In-order circular prefetch buffer with three pointers:
//   alloc - advanced when a fetch request is accepted (slot reserved, not filled)
//   fill  - advanced when a kept IMEM response writes its instruction
//   head  - advanced when ID consumes the oldest filled slot
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   flush                      clear every slot and rewind all pointers
//   alloc_en/alloc_pc          reserve a slot for a request at alloc_pc
//   fill_en/fill_instr         complete the slot at the fill pointer
//   pop_en                     retire the head slot
//   head_valid/pc/instr        contents of the head slot
//   alloc_cnt                  slots reserved and not yet popped
//   unfilled_cnt               slots reserved whose response is still pending
//   trap_en/trap_pc/head_misalign  (IF_MISALIGN_TRAP_EN only) flush that leaves a
//                              single ready-made misaligned entry
module fetch_buffer
   import if_pkg::*;
#(
   parameter int  XLEN  = 32,
   parameter int  DEPTH = 4,
   localparam int PW    = ptr_width(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
`ifdef IF_MISALIGN_TRAP_EN
   input  logic            trap_en,
   input  logic [XLEN-1:0] trap_pc,
   output logic            head_misalign,
`endif
   input  logic            alloc_en,
   input  logic [XLEN-1:0] alloc_pc,
   input  logic            fill_en,
   input  logic [31:0]     fill_instr,
   input  logic            pop_en,
   output logic            head_valid,
   output logic [XLEN-1:0] head_pc,
   output logic [31:0]     head_instr,
   output logic [CW-1:0]   alloc_cnt,
   output logic [CW-1:0]   unfilled_cnt
);

   logic [CW-1:0] alloc_ptr;
   logic [CW-1:0] fill_ptr;
   logic [CW-1:0] head_ptr;
   logic [PW-1:0] alloc_idx;
   logic [PW-1:0] fill_idx;
   logic [PW-1:0] head_idx;
   fetch_entry_t  mem [DEPTH];

   assign alloc_idx    = alloc_ptr[PW-1:0];
   assign fill_idx     = fill_ptr[PW-1:0];
   assign head_idx     = head_ptr[PW-1:0];
   assign alloc_cnt    = alloc_ptr - head_ptr;
   assign unfilled_cnt = alloc_ptr - fill_ptr;

   assign head_valid = mem[head_idx].filled;
   assign head_pc    = XLEN'(mem[head_idx].pc);
   assign head_instr = mem[head_idx].instr;
`ifdef IF_MISALIGN_TRAP_EN
   assign head_misalign = mem[head_idx].misalign;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         head_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
`ifdef IF_MISALIGN_TRAP_EN
         if (trap_en) begin
            // slot 0 becomes a complete entry; nothing is outstanding for it
            mem[0]    <= '{pc: FETCH_XLEN'(trap_pc), instr: NOP_INSTR,
                           filled: 1'b1, misalign: 1'b1};
            alloc_ptr <= CW'(1);
            fill_ptr  <= CW'(1);
         end else begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
         end
`else
         alloc_ptr <= '0;
         fill_ptr  <= '0;
`endif
      end else begin
         // pop is written first so an alloc into the same slot (full + pop) wins
         if (pop_en) begin
            mem[head_idx].filled <= 1'b0;
            head_ptr             <= head_ptr + CW'(1);
         end
         if (fill_en) begin
            mem[fill_idx].instr  <= fill_instr;
            mem[fill_idx].filled <= 1'b1;
            fill_ptr             <= fill_ptr + CW'(1);
         end
         if (alloc_en) begin
            mem[alloc_idx].pc       <= FETCH_XLEN'(alloc_pc);
            mem[alloc_idx].instr    <= NOP_INSTR;
            mem[alloc_idx].filled   <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            mem[alloc_idx].misalign <= 1'b0;
`endif
            alloc_ptr               <= alloc_ptr + CW'(1);
         end
      end
   end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry in-order prefetch buffer.
// Owns the fetch PC, the IMEM request logic and the count of stale responses
// still to be discarded after a redirect (drop_cnt).
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   redirect_valid/redirect_pc       EX redirect; flushes the buffer
//   imem_req_valid/ready/addr        fetch request channel
//   imem_resp_valid/data             in-order responses, no backpressure
//   id_valid/ready, id_pc, id_instr  head of the buffer towards decode
//   id_misalign                      (IF_MISALIGN_TRAP_EN only) head is a
//                                    misaligned-target trap entry
// Macro IF_MISALIGN_TRAP_EN: a misaligned redirect target produces a single
// trap entry and halts fetch until the next redirect. Without it the low two
// bits of redirect_pc are ignored.
module if_fetch_queue
   import if_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [31:0]     id_instr
`ifdef IF_MISALIGN_TRAP_EN
   ,
   output logic            id_misalign
`endif
);

   localparam int          CW      = ptr_width(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] redirect_tgt;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   alloc_cnt;
   logic [CW-1:0]   unfilled_cnt;
   logic [CW:0]     committed;
   logic            head_valid;
   logic [XLEN-1:0] head_pc;
   logic [31:0]     head_instr;
   logic            pop;
   logic            req_fire;
   logic            resp_keep;
   logic            resp_drop;
   logic            redirect_trap;
   logic            fetch_halt;

`ifdef IF_MISALIGN_TRAP_EN
   logic            head_misalign;
   assign redirect_trap = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign redirect_tgt  = redirect_pc;
   assign id_misalign   = head_valid && head_misalign;
`else
   assign redirect_trap = 1'b0;
   assign redirect_tgt  = redirect_pc & ~XLEN'(3);
`endif

   assign pop = head_valid && id_ready;

   // Slots already promised: live entries plus stale responses still coming.
   // A same-cycle pop frees its slot in time for a new request.
   assign committed = {1'b0, alloc_cnt} - {{CW{1'b0}}, pop} + {1'b0, drop_cnt};

   assign imem_req_valid = !reset && !redirect_valid && !fetch_halt && (committed < DEPTH_W);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign resp_keep      = imem_resp_valid && (drop_cnt == '0);
   assign resp_drop      = imem_resp_valid && (drop_cnt != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc   <= RESET_PC;
         drop_cnt   <= '0;
         fetch_halt <= 1'b0;
      end else if (redirect_valid) begin
         fetch_pc   <= redirect_tgt;
         // every pending response becomes stale; one arriving now is already spent
         drop_cnt   <= drop_cnt + unfilled_cnt - {{(CW-1){1'b0}}, imem_resp_valid};
         fetch_halt <= redirect_trap;
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + XLEN'(4);
         end
         if (resp_drop) begin
            drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   fetch_buffer #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_fetch_buffer (
      .clk           (clk),
      .reset         (reset),
      .flush         (redirect_valid),
`ifdef IF_MISALIGN_TRAP_EN
      .trap_en       (redirect_trap),
      .trap_pc       (redirect_pc),
      .head_misalign (head_misalign),
`endif
      .alloc_en      (req_fire),
      .alloc_pc      (fetch_pc),
      .fill_en       (resp_keep),
      .fill_instr    (imem_resp_data),
      .pop_en        (pop),
      .head_valid    (head_valid),
      .head_pc       (head_pc),
      .head_instr    (head_instr),
      .alloc_cnt     (alloc_cnt),
      .unfilled_cnt  (unfilled_cnt)
   );

   assign id_valid = head_valid;
   assign id_pc    = head_valid ? head_pc : '0;
   assign id_instr = head_valid ? head_instr : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_queue.sv
`timescale 1ns/1ps
module tb_if_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
`ifdef IF_MISALIGN_TRAP_EN
   logic        id_misalign;
`endif

   always #5 clk = ~clk;

   if_fetch_queue #(
      .XLEN     (32),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .id_valid        (id_valid),
      .id_ready        (id_ready),
      .id_pc           (id_pc),
      .id_instr        (id_instr)
`ifdef IF_MISALIGN_TRAP_EN
      ,
      .id_misalign     (id_misalign)
`endif
   );

   int checks = 0;
   int errors = 0;

   // IMEM model: accepted requests waiting for their response cycle
   typedef struct {
      logic [31:0] addr;
      int          due;
   } imem_req_t;
   imem_req_t imem_q[$];
   int        cycle;
   int        last_due;
   int        lat_min = 1;
   int        lat_max = 1;

   // reference model: the next PC ID must see and the next PC IMEM must be asked for
   logic [31:0] exp_pc;
   logic [31:0] exp_req;
   bit          halted;
   int          n_pops;
   int          n_reqs;

   // what happened in the cycle just completed
   logic        obs_req_valid;
   logic [31:0] obs_req_addr;
   logic        obs_id_valid;
   logic [31:0] obs_id_pc;
   logic        obs_misalign;
   bit          obs_pop;
   bit          obs_fire;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
   endfunction

   function automatic logic [31:0] effective_target(input logic [31:0] t);
`ifdef IF_MISALIGN_TRAP_EN
      return t;
`else
      return t & 32'hFFFF_FFFC;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // one clock cycle: sample and check at the falling edge, then advance the IMEM model
   task automatic tick();
      logic [31:0] t;
      int          due;
      @(negedge clk);
      obs_req_valid = imem_req_valid;
      obs_req_addr  = imem_req_addr;
      obs_id_valid  = id_valid;
      obs_id_pc     = id_pc;
      obs_fire      = imem_req_valid && imem_req_ready;
      obs_pop       = id_valid && id_ready;
`ifdef IF_MISALIGN_TRAP_EN
      obs_misalign  = id_misalign;
`else
      obs_misalign  = 1'b0;
`endif
      if (obs_pop) begin
         chk("pop_pc", id_pc, exp_pc);
         chk("pop_instr", id_instr, (exp_pc[1:0] != 2'b00) ? NOP : imem_word(exp_pc));
`ifdef IF_MISALIGN_TRAP_EN
         chk("pop_misalign", 32'(id_misalign), 32'(exp_pc[1:0] != 2'b00));
`endif
         exp_pc = exp_pc + 32'd4;
         n_pops++;
      end else if (!id_valid) begin
         chk("idle_pc", id_pc, 32'h0);
         chk("idle_instr", id_instr, NOP);
      end
      if (redirect_valid) begin
         chk("req_in_redirect", 32'(imem_req_valid), 32'h0);
      end else if (halted) begin
         chk("req_while_halted", 32'(imem_req_valid), 32'h0);
      end else if (obs_fire) begin
         chk("req_addr", imem_req_addr, exp_req);
         chk("inflight_bound", 32'((imem_q.size() + int'(imem_resp_valid)) < DEPTH), 32'h1);
         exp_req = exp_req + 32'd4;
         n_reqs++;
      end
      if (redirect_valid) begin
         t       = effective_target(redirect_pc);
         exp_pc  = t;
         exp_req = t;
         halted  = (t[1:0] != 2'b00);
      end
      @(posedge clk);
      #1;
      if (obs_fire) begin
         due = cycle + int'($urandom_range(lat_max, lat_min));
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         imem_q.push_back('{addr: obs_req_addr, due: due});
      end
      cycle++;
      if (imem_q.size() > 0 && imem_q[0].due <= cycle) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = imem_word(imem_q[0].addr);
         void'(imem_q.pop_front());
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
      end
   endtask

   // assert reset (takes effect at once), check reset outputs, release after two edges
   task automatic apply_reset();
      reset           = 1'b1;
      redirect_valid  = 1'b0;
      imem_resp_valid = 1'b0;
      id_ready        = 1'b0;
      imem_req_ready  = 1'b0;
      imem_q.delete();
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_req_addr", imem_req_addr, RESET_PC);
      chk("rst_id_valid", 32'(id_valid), 32'h0);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_id_instr", id_instr, NOP);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      cycle    = 0;
      last_due = -1;
      exp_pc   = RESET_PC;
      exp_req  = RESET_PC;
      halted   = 1'b0;
      n_pops   = 0;
      n_reqs   = 0;
   endtask

   task automatic wait_pop(input string tag, input logic [31:0] exp);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!obs_pop && n < 20);
      chk({tag, "_seen"}, 32'(obs_pop), 32'h1);
      if (obs_pop) chk(tag, obs_id_pc, exp);
   endtask

   initial begin
      // steady stream, 1-cycle IMEM
      apply_reset();
      lat_min = 1; lat_max = 1;
      id_ready = 1'b1; imem_req_ready = 1'b1;
      tick();
      chk("s1_c0_req_valid", 32'(obs_req_valid), 32'h1);
      chk("s1_c0_req_addr", obs_req_addr, RESET_PC);
      chk("s1_c0_id_valid", 32'(obs_id_valid), 32'h0);
      tick();
      chk("s1_c1_id_valid", 32'(obs_id_valid), 32'h0);
      tick();
      chk("s1_c2_id_valid", 32'(obs_id_valid), 32'h1);
      chk("s1_c2_id_pc", obs_id_pc, 32'h0);
      tick();
      chk("s1_c3_id_pc", obs_id_pc, 32'h4);
      tick();
      chk("s1_c4_id_pc", obs_id_pc, 32'h8);

      // fill up with ID stalled, then pop and request together
      apply_reset();
      id_ready = 1'b0; imem_req_ready = 1'b1;
      repeat (6) tick();
      chk("s2_req_count", n_reqs, 32'd4);
      chk("s2_full_req_valid", 32'(obs_req_valid), 32'h0);
      id_ready = 1'b1;
      tick();
      chk("s2_pop", 32'(obs_pop), 32'h1);
      chk("s2_pop_pc", obs_id_pc, 32'h0);
      chk("s2_req_valid", 32'(obs_req_valid), 32'h1);
      chk("s2_req_addr", obs_req_addr, 32'h10);

      // redirect with two requests in flight, 3-cycle IMEM
      apply_reset();
      lat_min = 3; lat_max = 3;
      id_ready = 1'b1; imem_req_ready = 1'b1;
      tick();
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect_valid = 1'b0;
      chk("s3_redirect_req_valid", 32'(obs_req_valid), 32'h0);
      tick();
      chk("s3_restart_addr", obs_req_addr, 32'h100);
      wait_pop("s3_first_pc", 32'h100);

      // redirect coinciding with a pop of 0x8
      apply_reset();
      lat_min = 1; lat_max = 1;
      id_ready = 1'b1; imem_req_ready = 1'b1;
      repeat (4) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      tick();
      redirect_valid = 1'b0;
      chk("s4_pop", 32'(obs_pop), 32'h1);
      chk("s4_pop_pc", obs_id_pc, 32'h8);
      chk("s4_req_valid", 32'(obs_req_valid), 32'h0);
      wait_pop("s4_next_pc", 32'h200);

      // toggling request ready, 3-cycle IMEM
      apply_reset();
      lat_min = 3; lat_max = 3;
      id_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         imem_req_ready = (i % 2 == 0);
         tick();
      end
      chk("s5_progress", 32'(n_pops > 10), 32'h1);

      // PC wrap-around
      lat_min = 1; lat_max = 1;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect_valid = 1'b0;
      wait_pop("s6_wrap0", 32'hFFFF_FFF8);
      wait_pop("s6_wrap1", 32'hFFFF_FFFC);
      wait_pop("s6_wrap2", 32'h0000_0000);

`ifdef IF_MISALIGN_TRAP_EN
      id_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h102;
      tick();
      redirect_valid = 1'b0;
      tick();
      chk("s7_trap_valid", 32'(obs_id_valid), 32'h1);
      chk("s7_trap_misalign", 32'(obs_misalign), 32'h1);
      chk("s7_trap_pc", obs_id_pc, 32'h102);
      chk("s7_trap_no_req", 32'(obs_req_valid), 32'h0);
      id_ready = 1'b1;
      repeat (5) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h400;
      tick();
      redirect_valid = 1'b0;
      wait_pop("s7_resume_pc", 32'h400);
`else
      redirect_valid = 1'b1; redirect_pc = 32'h301;
      tick();
      redirect_valid = 1'b0;
      wait_pop("s7_aligned_pc", 32'h300);
`endif

      // reset while the buffer is full
      id_ready = 1'b0;
      repeat (8) tick();
      chk("s8_full_before_reset", 32'(obs_id_valid), 32'h1);
      apply_reset();
      id_ready = 1'b1; imem_req_ready = 1'b1;
      tick();
      chk("s8_restart_addr", obs_req_addr, RESET_PC);

      // random traffic against the model
      apply_reset();
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 800; i++) begin
         id_ready       = ($urandom % 10) < 7;
         imem_req_ready = ($urandom % 4) != 0;
         redirect_valid = ($urandom % 25) == 0;
         redirect_pc    = $urandom;
         if ($urandom % 4 != 0) redirect_pc[1:0] = 2'b00;
         tick();
      end
      redirect_valid = 1'b0;
      chk("rand_progress", 32'(n_pops > 50), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
